// File: rtl/exhaustive_sweep_misr_if.sv
// Bus between the sweep/MISR engine and whoever controls it and owns the
// combinational circuit under test. Widths follow the engine parameters.
interface exhaustive_sweep_misr_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int SIG_W = 16
);
    logic             start;
    logic             hold;
    logic [N_IN-1:0]  pattern_out;
    logic             pattern_valid;
    logic [N_OUT-1:0] response_in;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [N_IN:0]    count;

    // Controller / circuit-under-test side.
    modport master (
        output start, hold, response_in,
        input  pattern_out, pattern_valid, busy, done, signature, count
    );

    // Engine side.
    modport slave (
        input  start, hold, response_in,
        output pattern_out, pattern_valid, busy, done, signature, count
    );
endinterface

// File: rtl/exhaustive_sweep_misr.sv
// Exhaustive pattern sweep with MISR response compaction. Every vector
// 0..2^N_IN-1 is driven once; the circuit outputs are folded into a
// signature register so one final value stands in for the truth table.
module exhaustive_sweep_misr #(
    parameter int               N_IN  = 4,
    parameter int               N_OUT = 3,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SEED  = {SIG_W{1'b1}}
) (
    input logic                    clock,
    input logic                    reset,
    exhaustive_sweep_misr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [N_IN-1:0] PAT_ONE = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE = (N_IN + 1)'(1);

    state_t           state, state_nxt;
    logic [N_IN-1:0]  pattern;
    logic [N_IN:0]    cnt;
    logic [SIG_W-1:0] sig, sig_nxt, resp_ext;
    logic             last, load, step;
    logic             busy, done, pattern_valid;

    // Final vector of the sweep is the all-ones pattern.
    assign last = &pattern;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; hold only matters inside SWEEP, start only outside it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SWEEP;
            SWEEP:   if (!bus.hold && last) state_nxt = DONE;
            DONE:    if (bus.start) state_nxt = SWEEP;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and datapath controls decoded from state.
    always_comb begin
        busy          = (state == SWEEP);
        done          = (state == DONE);
        pattern_valid = busy && !bus.hold;
        step          = pattern_valid;
        load          = (state != SWEEP) && bus.start;
    end

    // MISR update: Galois shift with feedback taps, then fold in the response.
    always_comb begin
        resp_ext              = '0;
        resp_ext[N_OUT-1:0]   = bus.response_in;
        sig_nxt               = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ resp_ext;
    end

    // Pattern, count and signature registers; pattern parks at all-ones when done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            cnt     <= '0;
            sig     <= SEED;
        end else if (load) begin
            pattern <= '0;
            cnt     <= '0;
            sig     <= SEED;
        end else if (step) begin
            sig <= sig_nxt;
            cnt <= cnt + CNT_ONE;
            if (!last) pattern <= pattern + PAT_ONE;
        end
    end

    assign bus.pattern_out   = pattern;
    assign bus.pattern_valid = pattern_valid;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.signature     = sig;
    assign bus.count         = cnt;
endmodule
